// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b one bit per clock, LSB first, reusing a single
// full-subtractor slice (two chained half-subtractors) around one borrow flip-flop.
module serial_subtractor #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
   output logic             overflow
);

   localparam int unsigned CntW = $clog2(WIDTH) + 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] sa_q, sa_d;
   logic [WIDTH-1:0] sb_q, sb_d;
   logic [WIDTH-1:0] sd_q, sd_d;
   logic             bf_q, bf_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             a_msb_q, a_msb_d;
   logic             b_msb_q, b_msb_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             borrow_q, borrow_d;
   logic             ovf_q, ovf_d;

   // Full-subtractor slice built from two half-subtractors.
   logic x, y, d1, b1, dbit, b2, bnext;
   assign x     = sa_q[0];
   assign y     = sb_q[0];
   assign d1    = x ^ y;
   assign b1    = ~x & y;
   assign dbit  = d1 ^ bf_q;
   assign b2    = ~d1 & bf_q;
   assign bnext = b1 | b2;

   always_comb begin
      state_d  = state_q;
      sa_d     = sa_q;
      sb_d     = sb_q;
      sd_d     = sd_q;
      bf_d     = bf_q;
      cnt_d    = cnt_q;
      a_msb_d  = a_msb_q;
      b_msb_d  = b_msb_q;
      busy_d   = busy_q;
      done_d   = done_q;
      diff_d   = diff_q;
      borrow_d = borrow_q;
      ovf_d    = ovf_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               sa_d    = a;
               sb_d    = b;
               bf_d    = 1'b0;
               cnt_d   = '0;
               a_msb_d = a[WIDTH-1];
               b_msb_d = b[WIDTH-1];
               busy_d  = 1'b1;
               state_d = StShift;
            end
         end
         StShift: begin
            sd_d  = {dbit, sd_q[WIDTH-1:1]};
            sa_d  = sa_q >> 1;
            sb_d  = sb_q >> 1;
            bf_d  = bnext;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LastCnt) begin
               // Publish including the bit produced on this very edge.
               diff_d   = {dbit, sd_q[WIDTH-1:1]};
               borrow_d = bnext;
               ovf_d    = (a_msb_q != b_msb_q) && (dbit != a_msb_q);
               busy_d   = 1'b0;
               done_d   = 1'b1;
               state_d  = StDone;
            end
         end
         StDone: begin
            done_d  = 1'b0;
            state_d = StIdle;
         end
         default: begin
            busy_d  = 1'b0;
            done_d  = 1'b0;
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= StIdle;
         sa_q     <= '0;
         sb_q     <= '0;
         sd_q     <= '0;
         bf_q     <= 1'b0;
         cnt_q    <= '0;
         a_msb_q  <= 1'b0;
         b_msb_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         sa_q     <= sa_d;
         sb_q     <= sb_d;
         sd_q     <= sd_d;
         bf_q     <= bf_d;
         cnt_q    <= cnt_d;
         a_msb_q  <= a_msb_d;
         b_msb_q  <= b_msb_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         diff_q   <= diff_d;
         borrow_q <= borrow_d;
         ovf_q    <= ovf_d;
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign diff       = diff_q;
   assign borrow_out = borrow_q;
   assign overflow   = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: an 8-bit instance for directed/streaming/reset
// cases and a 4-bit instance for an exhaustive operand sweep.
module tb_serial_subtractor;

   typedef struct {
      logic [7:0] diff;
      logic       bo;
      logic       ov;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       start8, busy8, done8, bo8, ov8;
   logic [7:0] a8, b8, diff8;
   logic       start4, busy4, done4, bo4, ov4;
   logic [3:0] a4, b4, diff4;

   int   n_pass  = 0;
   int   n_total = 0;
   exp_t q8[$];
   exp_t q4[$];
   exp_t e8, e4;
   logic [7:0] last8;
   logic [3:0] last4;
   int   run8, run4;

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(8)) dut8 (
      .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8), .overflow(ov8)
   );

   serial_subtractor #(.WIDTH(4)) dut4 (
      .clk(clk), .reset(reset), .start(start4), .a(a4), .b(b4),
      .busy(busy4), .done(done4), .diff(diff4), .borrow_out(bo4), .overflow(ov4)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic exp_t model(input int w, input int ai, input int bi);
      exp_t r;
      int   di;
      di     = (ai - bi) & ((1 << w) - 1);
      r.diff = 8'(di);
      r.bo   = (ai < bi);
      r.ov   = (((ai >> (w - 1)) & 1) != ((bi >> (w - 1)) & 1)) &&
               (((di >> (w - 1)) & 1) != ((ai >> (w - 1)) & 1));
      return r;
   endfunction

   always @(negedge clk) begin
      if (reset) begin
         last8 = '0;
         run8  = 0;
      end else begin
         if (busy8 && done8) check("busy_done_overlap8", 1, 0);
         if (busy8) run8++;
         if (done8) begin
            check("busy_len8", run8, 8);
            run8 = 0;
            if (q8.size() == 0) check("unexpected_done8", 1, 0);
            else begin
               e8 = q8.pop_front();
               check("diff8", diff8, e8.diff);
               check("borrow8", bo8, e8.bo);
               check("overflow8", ov8, e8.ov);
            end
            last8 = diff8;
         end else check("diff_hold8", diff8, last8);
      end
   end

   always @(negedge clk) begin
      if (reset) begin
         last4 = '0;
         run4  = 0;
      end else begin
         if (busy4 && done4) check("busy_done_overlap4", 1, 0);
         if (busy4) run4++;
         if (done4) begin
            check("busy_len4", run4, 4);
            run4 = 0;
            if (q4.size() == 0) check("unexpected_done4", 1, 0);
            else begin
               e4 = q4.pop_front();
               check("diff4", diff4, e4.diff);
               check("borrow4", bo4, e4.bo);
               check("overflow4", ov4, e4.ov);
            end
            last4 = diff4;
         end else check("diff_hold4", diff4, last4);
      end
   end

   task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] ed,
                      input logic ebo, input logic eov);
      exp_t e;
      e.diff = ed;
      e.bo   = ebo;
      e.ov   = eov;
      @(negedge clk);
      a8 = a;
      b8 = b;
      start8 = 1'b1;
      q8.push_back(e);
      @(negedge clk);
      start8 = 1'b0;
      for (int i = 0; i < 20 && !done8; i++) @(negedge clk);
      if (!done8) check("done_timeout8", 0, 1);
   endtask

   task automatic op4(input int a, input int b);
      @(negedge clk);
      a4 = 4'(a);
      b4 = 4'(b);
      start4 = 1'b1;
      q4.push_back(model(4, a, b));
      @(negedge clk);
      start4 = 1'b0;
      for (int i = 0; i < 12 && !done4; i++) @(negedge clk);
      if (!done4) check("done_timeout4", 0, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      start8 = 1'b0; a8 = '0; b8 = '0;
      start4 = 1'b0; a4 = '0; b4 = '0;
      repeat (2) @(negedge clk);
      check("rst_busy8", busy8, 0);
      check("rst_done8", done8, 0);
      check("rst_diff8", diff8, 0);
      check("rst_borrow8", bo8, 0);
      check("rst_ovf8", ov8, 0);
      check("rst_busy4", busy4, 0);
      check("rst_diff4", diff4, 0);
      #2 reset = 1'b0;

      op8(8'd200, 8'd55, 8'h91, 1'b0, 1'b0);
      op8(8'd5, 8'd10, 8'hFB, 1'b1, 1'b0);
      op8(8'hA5, 8'hA5, 8'h00, 1'b0, 1'b0);
      op8(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
      op8(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);

      // start held high; accepts land every 10 cycles, operands change every cycle
      @(negedge clk);
      for (int i = 0; i < 30; i++) begin
         if (i != 0) @(negedge clk);
         a8 = 8'(i * 37 + 11);
         b8 = 8'(i * 91 + 3);
         start8 = 1'b1;
         if (i % 10 == 0) q8.push_back(model(8, int'(a8), int'(b8)));
      end
      @(negedge clk);
      start8 = 1'b0;
      repeat (12) @(negedge clk);
      check("stream_q_empty", q8.size(), 0);

      // abort mid-SHIFT with an asynchronous reset between edges
      @(negedge clk);
      a8 = 8'h11; b8 = 8'h22; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      check("busy_before_abort", busy8, 1);
      #2 reset = 1'b1;
      #1;
      check("abort_busy", busy8, 0);
      check("abort_done", done8, 0);
      check("abort_diff", diff8, 0);
      check("abort_borrow", bo8, 0);
      check("abort_ovf", ov8, 0);
      @(negedge clk);
      #2 reset = 1'b0;
      repeat (12) @(negedge clk);
      op8(8'd3, 8'd1, 8'd2, 1'b0, 1'b0);

      for (int ai = 0; ai < 16; ai++)
         for (int bi = 0; bi < 16; bi++)
            op4(ai, bi);

      repeat (4) @(negedge clk);
      check("final_q8_empty", q8.size(), 0);
      check("final_q4_empty", q4.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
